// File: rtl/fetch_pkg.sv
// fetch_pkg: fetch FSM states and the branch opcode/cond encodings shared with decode.
package fetch_pkg;
  typedef enum logic [1:0] {REQ, WAIT, DROP} state_t;
  localparam logic [3:0] OP_COND_BRANCH   = 4'b1101;
  localparam logic [4:0] OP_UNCOND_BRANCH = 5'b11100;
  localparam logic [3:0] COND_AL          = 4'b1110;
  localparam logic [3:0] COND_NV          = 4'b1111;
endpackage

// File: rtl/branch_predict.sv
// branch_predict: static predictor, backward conditional and all unconditional branches taken.
module branch_predict import fetch_pkg::*; #(
  parameter int ADDR_W = 32
) (
  input  logic [15:0]       instr,
  input  logic [ADDR_W-1:0] pc,
  output logic              taken,
  output logic [ADDR_W-1:0] target
);
  logic cond, uncond;
  always_comb begin
    cond   = instr[15:12] == OP_COND_BRANCH && instr[11:8] != COND_AL && instr[11:8] != COND_NV && instr[7];
    uncond = instr[15:11] == OP_UNCOND_BRANCH;
    taken  = cond || uncond;
    target = pc + ADDR_W'(4) + (uncond ? {{(ADDR_W-12){instr[10]}}, instr[10:0], 1'b0}
                                       : {{(ADDR_W-9){instr[7]}}, instr[7:0], 1'b0});
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, single-outstanding imem fetch and decode slot with redirect flush.
// Define FETCH_STATIC_PREDICT_EN to enable static branch prediction on captured instructions.
module fetch_stage import fetch_pkg::*; #(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [15:0]       imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [15:0]       id_instr,
  output logic [ADDR_W-1:0] id_pc,
  output logic              id_pred_taken
);
  state_t state;
  logic [ADDR_W-1:0] pc, next_pc;
  logic taken, fire;
`ifdef FETCH_STATIC_PREDICT_EN
  logic [ADDR_W-1:0] target;
  branch_predict #(.ADDR_W(ADDR_W)) u_bp (.instr(imem_rsp_data), .pc(pc), .taken(taken), .target(target));
  assign next_pc = taken ? target : pc + ADDR_W'(2);
`else
  assign taken   = 1'b0;
  assign next_pc = pc + ADDR_W'(2);
`endif
  assign imem_req_valid = !rst && state == REQ && (!id_valid || id_ready);
  assign fire           = imem_req_valid && imem_req_ready;
  assign imem_req_addr  = pc;
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= REQ;
      pc            <= RESET_PC;
      id_valid      <= 1'b0;
      id_instr      <= '0;
      id_pc         <= '0;
      id_pred_taken <= 1'b0;
    end else if (redirect_valid) begin
      pc       <= {redirect_pc[ADDR_W-1:1], 1'b0};
      id_valid <= 1'b0;
      // an accepted or still-pending read must be swallowed before refetching
      state    <= state == REQ ? (fire ? DROP : REQ) : (imem_rsp_valid ? REQ : DROP);
    end else begin
      if (id_ready) id_valid <= 1'b0;
      if (state == REQ && fire) state <= WAIT;
      if (state == DROP && imem_rsp_valid) state <= REQ;
      if (state == WAIT && imem_rsp_valid) begin
        state         <= REQ;
        id_valid      <= 1'b1;
        id_instr      <= imem_rsp_data;
        id_pc         <= pc;
        id_pred_taken <= taken;
        pc            <= next_pc;
      end
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage against a variable-latency memory model.
module tb_fetch_stage;
  localparam int AW = 32;
`ifdef FETCH_STATIC_PREDICT_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic imem_req_valid, imem_req_ready = 1'b1;
  logic [AW-1:0] imem_req_addr;
  logic imem_rsp_valid;
  logic [15:0] imem_rsp_data;
  logic redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic id_valid, id_ready = 1'b1, id_pred_taken;
  logic [15:0] id_instr;
  logic [AW-1:0] id_pc;
  int n_cmp = 0, n_bad = 0;
  int lat = 1, cnt = 0;
  logic [AW-1:0] paddr = '0;
  logic [15:0] special = 16'h0000;

  always #5 clk = ~clk;

  fetch_stage #(.ADDR_W(AW), .RESET_PC(32'h100)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
    .id_pred_taken(id_pred_taken)
  );

  // memory answers lat cycles after acceptance; 0x40 returns the programmable instruction
  always @(posedge clk)
    if (rst) cnt <= 0;
    else if (imem_req_valid && imem_req_ready) begin cnt <= lat; paddr <= imem_req_addr; end
    else if (cnt != 0) cnt <= cnt - 1;
  assign imem_rsp_valid = cnt == 1;
  assign imem_rsp_data  = paddr == 32'h40 ? special : {4'h0, paddr[11:0]};

  task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pred_case(input logic [15:0] ins, input logic exp_taken, input logic [AW-1:0] exp_next);
    special = ins;
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    for (int i = 0; i < 8 && !id_valid; i++) tick();
    chk("pred_wait", id_valid, 1);
    chk("pred_pc", id_pc, 32'h40);
    chk("pred_instr", id_instr, ins);
    chk("pred_taken", id_pred_taken, exp_taken);
    chk("pred_req_valid", imem_req_valid, 1);
    chk("pred_next_addr", imem_req_addr, exp_next);
  endtask

  initial begin
    tick(); tick();
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_id_valid", id_valid, 0);
    chk("rst_id_instr", id_instr, 0);
    chk("rst_id_pc", id_pc, 0);
    chk("rst_pred", id_pred_taken, 0);
    rst = 1'b0; #1;
    chk("first_req_valid", imem_req_valid, 1);
    chk("first_req_addr", imem_req_addr, 32'h100);
    tick();
    chk("wait_req_valid", imem_req_valid, 0);
    chk("wait_id_valid", id_valid, 0);
    tick();
    chk("i0_valid", id_valid, 1);
    chk("i0_pc", id_pc, 32'h100);
    chk("i0_instr", id_instr, 16'h0100);
    chk("i1_req_addr", imem_req_addr, 32'h102);
    tick(); tick();
    chk("i1_pc", id_pc, 32'h102);
    chk("i2_req_addr", imem_req_addr, 32'h104);
    tick();
    id_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("stall_req_valid", imem_req_valid, 0);
      chk("stall_id_valid", id_valid, 1);
      chk("stall_id_pc", id_pc, 32'h104);
      chk("stall_id_instr", id_instr, 16'h0104);
      tick();
    end
    id_ready = 1'b1; #1;
    chk("resume_req_valid", imem_req_valid, 1);
    chk("resume_req_addr", imem_req_addr, 32'h106);
    tick();
    chk("resume_id_valid", id_valid, 0);
    tick();
    chk("i3_pc", id_pc, 32'h106);
    chk("i4_req_addr", imem_req_addr, 32'h108);
    lat = 2;
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0; #1;
    chk("rdw_id_valid", id_valid, 0);
    chk("rdw_req_valid", imem_req_valid, 0);
    tick();
    chk("rdw_drop_id_valid", id_valid, 0);
    chk("rdw_req_valid2", imem_req_valid, 1);
    chk("rdw_req_addr", imem_req_addr, 32'h200);
    lat = 1;
    tick(); tick();
    chk("rdw_i_pc", id_pc, 32'h200);
    chk("rdw_i_instr", id_instr, 16'h0200);
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h301;
    tick();
    redirect_valid = 1'b0; #1;
    chk("rdr_id_valid", id_valid, 0);
    chk("rdr_req_valid", imem_req_valid, 1);
    chk("rdr_req_addr", imem_req_addr, 32'h300);
    tick(); tick();
    chk("rdr_i_pc", id_pc, 32'h300);
    chk("rdr_next_addr", imem_req_addr, 32'h302);
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect_valid = 1'b0; #1;
    chk("rda_id_valid", id_valid, 0);
    chk("rda_req_valid", imem_req_valid, 0);
    tick();
    chk("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFE);
    tick(); tick();
    chk("wrap_id_pc", id_pc, 32'hFFFF_FFFE);
    chk("wrap_next_addr", imem_req_addr, 32'h0);
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    tick();
    redirect_valid = 1'b0; #1;
    chk("rdn_req_valid", imem_req_valid, 1);
    chk("rdn_req_addr", imem_req_addr, 32'h80);
    chk("rdn_id_valid", id_valid, 0);
    imem_req_ready = 1'b1;
    tick(); tick();
    chk("rdn_i_pc", id_pc, 32'h80);
    pred_case(16'hD1FE, PE, PE ? 32'h40 : 32'h42);
    pred_case(16'hE7FE, PE, PE ? 32'h40 : 32'h42);
    pred_case(16'hD101, 1'b0, 32'h42);
    pred_case(16'hDEFE, 1'b0, 32'h42);
    lat = 2;
    tick();
    rst = 1'b1; #1;
    chk("rstw_req_valid", imem_req_valid, 0);
    tick();
    rst = 1'b0; #1;
    chk("rstw_id_valid", id_valid, 0);
    chk("rstw_id_pc", id_pc, 0);
    chk("rstw_req_valid2", imem_req_valid, 1);
    chk("rstw_req_addr", imem_req_addr, 32'h100);
    tick();
    chk("rstw_no_stale", id_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
